// File: rtl/debug_screen_pkg.sv
// Shared constants and types for the debug-screen register path.
// Sizes here are the defaults; modules may override them through parameters.
package debug_screen_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam int REG_DW  = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } snap_state_t;

  typedef logic [REG_DW-1:0] reg_bank_t [REG_NUM];

endpackage

// File: rtl/sync_edge_det.sv
// Single-edge detector for a level already synchronous to clk_i (polarity set by RISE).
// Latency: edge_o is combinational in the cycle the new level is first seen; no backpressure.
module sync_edge_det #(
  parameter bit RISE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic edge_o
);

  logic sig_q;

  // Reset to the idle level of the watched edge so an already-asserted input
  // does not look like an edge on the first cycle out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= RISE;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign edge_o = RISE ? (sig_i & ~sig_q) : (~sig_i & sig_q);

endmodule

// File: rtl/debug_reg_snapshot.sv
// Live debug register bank copied atomically into a display bank on each vsync edge.
// Latency: snapshot lands one clk after the edge; regData read is combinational; no backpressure.
// Optional DEBUG_SCREEN_CHANGE_MARK_EN adds regChanged, a per-register changed-since-last-frame flag.
module debug_reg_snapshot #(
  parameter int REG_NUM      = debug_screen_pkg::REG_NUM,
  parameter int REG_AW       = debug_screen_pkg::REG_AW,
  parameter int REG_DW       = debug_screen_pkg::REG_DW,
  parameter bit SNAP_ON_RISE = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_we,
  input  logic [REG_AW-1:0] cpu_waddr,
  input  logic [REG_DW-1:0] cpu_wdata,
  input  logic              snap_hold,
  input  logic              vsync,
  input  logic [REG_AW-1:0] regAddr,
  output logic [REG_DW-1:0] regData,
  output logic              snap_pulse,
  output logic [15:0]       frame_cnt
`ifdef DEBUG_SCREEN_CHANGE_MARK_EN
  ,
  output logic              regChanged
`endif
);

  import debug_screen_pkg::*;

  snap_state_t       state_q, state_d;
  logic              vs_edge;
  logic              snap_fire;
  logic              snap_pulse_q;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [REG_DW-1:0] live_q    [REG_NUM];
  logic [REG_DW-1:0] display_q [REG_NUM];
  logic [REG_DW-1:0] snap_src  [REG_NUM];

  sync_edge_det #(
    .RISE (SNAP_ON_RISE)
  ) u_vsync_edge (
    .clk_i  (clk),
    .rst_ni (resetn),
    .sig_i  (vsync),
    .edge_o (vs_edge)
  );

  // HOLD is left only through one RUN cycle, so an edge coinciding with the
  // release is ignored and the following edge snapshots.
  always_comb begin
    state_d   = state_q;
    snap_fire = 1'b0;
    case (state_q)
      RUN: begin
        if (snap_hold) begin
          state_d = HOLD;
        end else begin
          snap_fire = vs_edge;
        end
      end
      HOLD: begin
        if (!snap_hold) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Copy source forwards a same-cycle CPU write so it is not lost to the frame.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      snap_src[i] = (cpu_we && (cpu_waddr == REG_AW'(i))) ? cpu_wdata : live_q[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < REG_NUM; i++) begin
        live_q[i] <= '0;
      end
    end else if (cpu_we) begin
      live_q[cpu_waddr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < REG_NUM; i++) begin
        display_q[i] <= '0;
      end
    end else if (snap_fire) begin
      for (int i = 0; i < REG_NUM; i++) begin
        display_q[i] <= snap_src[i];
      end
    end
  end

  assign frame_cnt_d = snap_fire ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_q  <= '0;
      snap_pulse_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      snap_pulse_q <= snap_fire;
    end
  end

  assign regData    = display_q[regAddr];
  assign snap_pulse = snap_pulse_q;
  assign frame_cnt  = frame_cnt_q;

`ifdef DEBUG_SCREEN_CHANGE_MARK_EN
  logic [REG_NUM-1:0] chg_mask_q, chg_mask_d;

  // Mask only moves on snapshots, so it stays frozen while held.
  always_comb begin
    chg_mask_d = chg_mask_q;
    if (snap_fire) begin
      for (int i = 0; i < REG_NUM; i++) begin
        chg_mask_d[i] = (snap_src[i] != display_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chg_mask_q <= '0;
    end else begin
      chg_mask_q <= chg_mask_d;
    end
  end

  assign regChanged = chg_mask_q[regAddr];
`endif

endmodule
